// File: rtl/tpu_pkg.sv
// Shared types and constants for the TPU result-dump path.
// Used by tpu_result_writer and its testbench.
package tpu_pkg;

    localparam int ROW_BYTES     = 64;
    localparam int BEATS_PER_ROW = ROW_BYTES * 8 / 64;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        AW,
        W,
        B
    } writer_state_e;

endpackage

// File: rtl/tpu_row_serializer.sv
// Holds one result row and presents it 64 bits at a time, lowest beat first.
// A beat advances only on a W handshake; last_o marks the final beat of the row.
module tpu_row_serializer #(
    parameter int ROW_W  = 512,
    parameter int BEAT_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [ROW_W-1:0]  row_i,
    input  logic              advance_i,
    output logic [BEAT_W-1:0] beat_o,
    output logic              last_o
);

    localparam int BEATS = ROW_W / BEAT_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    logic [ROW_W-1:0] row_q, row_d;
    logic [CNT_W-1:0] beat_q, beat_d;

    always_comb begin
        row_d  = row_q;
        beat_d = beat_q;
        if (load_i) begin
            row_d  = row_i;
            beat_d = '0;
        end else if (advance_i) begin
            row_d  = row_q >> BEAT_W;
            beat_d = beat_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q  <= '0;
            beat_q <= '0;
        end else begin
            row_q  <= row_d;
            beat_q <= beat_d;
        end
    end

    assign beat_o = row_q[BEAT_W-1:0];
    assign last_o = (beat_q == LAST_BEAT);

endmodule

// File: rtl/tpu_result_writer.sv
// Result-dump engine: reads result rows and writes each as one 8-beat AXI INCR burst.
// Optional macro TPU_RESULT_WRITER_PERF_EN adds stall and beat counters.
module tpu_result_writer
    import tpu_pkg::*;
#(
    parameter int AXI_DATA_WIDTH       = 64,
    parameter int SYSTOLIC_ARRAY_WIDTH = 16,
    parameter int ACCUM_WIDTH          = 32,
    parameter int ADDR_WIDTH           = 10
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        start,
    input  logic [ADDR_WIDTH-1:0]                       src_row,
    input  logic [15:0]                                 row_count,
    input  logic [31:0]                                 ddr_base,
    output logic                                        busy,
    output logic                                        done,
    output logic                                        error,
`ifdef TPU_RESULT_WRITER_PERF_EN
    output logic [31:0]                                 perf_stall_cycles,
    output logic [31:0]                                 perf_beats,
`endif
    output logic                                        buf_rd_en,
    output logic [ADDR_WIDTH-1:0]                       buf_rd_addr,
    input  logic [SYSTOLIC_ARRAY_WIDTH*ACCUM_WIDTH-1:0] buf_rd_data,
    output logic [31:0]                                 m_axi_awaddr,
    output logic [7:0]                                  m_axi_awlen,
    output logic [2:0]                                  m_axi_awsize,
    output logic [1:0]                                  m_axi_awburst,
    output logic                                        m_axi_awvalid,
    input  logic                                        m_axi_awready,
    output logic [AXI_DATA_WIDTH-1:0]                   m_axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0]                 m_axi_wstrb,
    output logic                                        m_axi_wlast,
    output logic                                        m_axi_wvalid,
    input  logic                                        m_axi_wready,
    input  logic [1:0]                                  m_axi_bresp,
    input  logic                                        m_axi_bvalid,
    output logic                                        m_axi_bready
);

    localparam int ROW_W   = SYSTOLIC_ARRAY_WIDTH * ACCUM_WIDTH;
    localparam int ALIGN_W = $clog2(ROW_BYTES);

    writer_state_e         state_q, state_d;
    logic [15:0]           r_q, r_d;
    logic [15:0]           count_q, count_d;
    logic [31:0]           awaddr_q, awaddr_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  rd_phase_q, rd_phase_d;
    logic                  error_q, error_d;
    logic                  done_q, done_d;

    logic ser_load, ser_last, fin;
    logic aw_vld, w_vld, b_rdy;

    assign aw_vld = (state_q == AW);
    assign w_vld  = (state_q == W);
    assign b_rdy  = (state_q == B);

    tpu_row_serializer #(
        .ROW_W (ROW_W),
        .BEAT_W(AXI_DATA_WIDTH)
    ) u_serializer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (ser_load),
        .row_i    (buf_rd_data),
        .advance_i(w_vld && m_axi_wready),
        .beat_o   (m_axi_wdata),
        .last_o   (ser_last)
    );

    always_comb begin
        state_d    = state_q;
        r_d        = r_q;
        count_d    = count_q;
        awaddr_d   = awaddr_q;
        rd_addr_d  = rd_addr_q;
        rd_phase_d = rd_phase_q;
        error_d    = error_q;
        done_d     = 1'b0;
        ser_load   = 1'b0;
        fin        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    error_d    = 1'b0;
                    r_d        = '0;
                    count_d    = row_count;
                    awaddr_d   = ddr_base;
                    rd_addr_d  = src_row;
                    rd_phase_d = 1'b0;
                    if (row_count == 16'd0) begin
                        done_d = 1'b1;
                    end else if (ddr_base[ALIGN_W-1:0] != '0) begin
                        error_d = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            // Read strobe in the first RD cycle, row data arrives in the second.
            RD: begin
                if (!rd_phase_q) begin
                    rd_phase_d = 1'b1;
                end else begin
                    rd_phase_d = 1'b0;
                    ser_load   = 1'b1;
                    state_d    = AW;
                end
            end
            AW: begin
                if (m_axi_awready) state_d = W;
            end
            W: begin
                if (m_axi_wready && ser_last) state_d = B;
            end
            B: begin
                if (m_axi_bvalid) begin
                    if (m_axi_bresp != AXI_RESP_OKAY) error_d = 1'b1;
                    r_d       = r_q + 16'd1;
                    awaddr_d  = awaddr_q + 32'(ROW_BYTES);
                    rd_addr_d = rd_addr_q + 1'b1;
                    if (r_q + 16'd1 == count_q) begin
                        fin     = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            r_q        <= '0;
            count_q    <= '0;
            awaddr_q   <= '0;
            rd_addr_q  <= '0;
            rd_phase_q <= 1'b0;
            error_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            r_q        <= r_d;
            count_q    <= count_d;
            awaddr_q   <= awaddr_d;
            rd_addr_q  <= rd_addr_d;
            rd_phase_q <= rd_phase_d;
            error_q    <= error_d;
            done_q     <= done_d;
        end
    end

    // Final B handshake ends the dump combinationally so done and busy switch together.
    assign busy          = (state_q != IDLE) && !fin;
    assign done          = done_q || fin;
    assign error         = error_q;
    assign buf_rd_en     = (state_q == RD) && !rd_phase_q;
    assign buf_rd_addr   = rd_addr_q;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awlen   = 8'(BEATS_PER_ROW - 1);
    assign m_axi_awsize  = 3'(ALIGN_W - 3);
    assign m_axi_awburst = AXI_BURST_INCR;
    assign m_axi_awvalid = aw_vld;
    assign m_axi_wstrb   = '1;
    assign m_axi_wlast   = w_vld && ser_last;
    assign m_axi_wvalid  = w_vld;
    assign m_axi_bready  = b_rdy;

`ifdef TPU_RESULT_WRITER_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    logic [31:0] stall_q, stall_d;
    logic [31:0] beats_q, beats_d;

    always_comb begin
        stall_d = stall_q;
        beats_d = beats_q;
        if (state_q == IDLE && start) begin
            stall_d = '0;
            beats_d = '0;
        end else begin
            if ((aw_vld && !m_axi_awready) || (w_vld && !m_axi_wready) ||
                (b_rdy && !m_axi_bvalid))
                stall_d = sat_inc(stall_q);
            if (w_vld && m_axi_wready) beats_d = sat_inc(beats_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            beats_q <= '0;
        end else begin
            stall_q <= stall_d;
            beats_q <= beats_d;
        end
    end

    assign perf_stall_cycles = stall_q;
    assign perf_beats        = beats_q;
`endif

endmodule

// File: tb/tb_tpu_result_writer.sv
// Scoreboard bench for tpu_result_writer: stimulus pushes expected reads, AWs and beats;
// a negedge monitor pops and compares on every DUT transfer.
module tb_tpu_result_writer;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [9:0]   src_row = '0;
    logic [15:0]  row_count = '0;
    logic [31:0]  ddr_base = '0;
    logic         busy, done, error, buf_rd_en;
    logic [9:0]   buf_rd_addr;
    logic [511:0] buf_rd_data = '0;
    logic [31:0]  awaddr;
    logic [7:0]   awlen;
    logic [2:0]   awsize;
    logic [1:0]   awburst;
    logic         awvalid, wlast, wvalid, bready;
    logic         awready = 1'b0;
    logic         wready = 1'b0;
    logic         bvalid = 1'b0;
    logic [1:0]   bresp = 2'b00;
    logic [63:0]  wdata;
    logic [7:0]   wstrb;
`ifdef TPU_RESULT_WRITER_PERF_EN
    logic [31:0]  perf_stall_cycles, perf_beats;
`endif

    always #5 clk = ~clk;

    tpu_result_writer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .src_row(src_row),
        .row_count(row_count), .ddr_base(ddr_base), .busy(busy), .done(done), .error(error),
`ifdef TPU_RESULT_WRITER_PERF_EN
        .perf_stall_cycles(perf_stall_cycles), .perf_beats(perf_beats),
`endif
        .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr), .buf_rd_data(buf_rd_data),
        .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
        .m_axi_awburst(awburst), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_bresp(bresp),
        .m_axi_bvalid(bvalid), .m_axi_bready(bready)
    );

    int checks = 0;
    int failures = 0;

    logic [511:0] mem [1024];
    logic [31:0]  exp_aw[$];
    logic [63:0]  exp_w[$];
    logic [9:0]   exp_rd[$];

    int cyc = 0, start_cyc = 0, last_lat = 0, aw_lat = 0;
    int done_cnt = 0, aw_count = 0, beat_in_row = 0, outstanding = 0;
    bit first_aw_pending = 0;
    bit p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0;
    logic [31:0] p_awaddr = '0;
    logic [63:0] p_wdata = '0;
    bit s_b_hs = 0, s_wlast_hs = 0, s_rd = 0;
    logic [9:0] s_rd_addr = '0;

    bit bp = 0;
    int err_burst = -1;
    int b_base = 0;
    int b_count = 0;
    bit b_pending = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_elem(input int mode, input int r, input logic [9:0] a,
                                             input int e);
        case (mode)
            0:       return 32'd37;
            1:       return 32'(r * 16 + e);
            default: return {6'd0, a, 16'(e)};
        endcase
    endfunction

    // Monitor: values are stable at negedge, so a transfer seen here completes at the next posedge.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            outstanding = 0; beat_in_row = 0; first_aw_pending = 0;
            p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0;
            s_b_hs = 0; s_wlast_hs = 0; s_rd = 0;
        end else begin
            if (start && !busy) begin
                start_cyc = cyc;
                first_aw_pending = 1;
            end
            if (awvalid && first_aw_pending) begin
                aw_lat = cyc - start_cyc;
                first_aw_pending = 0;
            end
            if (p_awv && !p_awr) begin
                chk("aw_hold_valid", awvalid, 1'b1);
                chk("aw_hold_addr", awaddr, p_awaddr);
            end
            if (p_wv && !p_wr) begin
                chk("w_hold_valid", wvalid, 1'b1);
                chk("w_hold_data", wdata, p_wdata);
            end
            if (buf_rd_en) begin
                if (exp_rd.size() == 0) chk("rd_unexpected", buf_rd_addr, 64'hdead);
                else chk("rd_addr", buf_rd_addr, exp_rd.pop_front());
            end
            if (awvalid && awready) begin
                chk("aw_inflight", outstanding, 0);
                if (exp_aw.size() == 0) chk("aw_unexpected", awaddr, 64'hdead);
                else chk("aw_addr", awaddr, exp_aw.pop_front());
                chk("aw_attr", {awlen, awsize, awburst, wstrb}, {8'd7, 3'd3, 2'b01, 8'hff});
                outstanding++;
                aw_count++;
            end
            if (wvalid && wready) begin
                if (exp_w.size() == 0) chk("w_unexpected", wdata, 64'hdead);
                else chk("w_data", wdata, exp_w.pop_front());
                chk("w_last", wlast, (beat_in_row == 7));
                beat_in_row = (beat_in_row + 1) % 8;
            end
            if (bvalid && bready) outstanding--;
            if (done) begin
                done_cnt++;
                last_lat = cyc - start_cyc;
            end
            s_b_hs     = bvalid && bready;
            s_wlast_hs = wvalid && wready && wlast;
            s_rd       = buf_rd_en;
            s_rd_addr  = buf_rd_addr;
            p_awv = awvalid; p_awr = awready; p_awaddr = awaddr;
            p_wv = wvalid; p_wr = wready; p_wdata = wdata;
        end
    end

    // Slave and result-buffer model, updated just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            b_pending = 0;
            bvalid = 1'b0;
            awready = 1'b0;
            wready = 1'b0;
            bresp = 2'b00;
        end else begin
            if (s_b_hs) begin
                b_pending = 0;
                bvalid = 1'b0;
                b_count++;
            end
            if (s_wlast_hs) b_pending = 1;
            if (b_pending && !bvalid) bvalid = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            bresp = (b_count - b_base == err_burst) ? 2'b10 : 2'b00;
            awready = bp ? ($urandom_range(0, 2) == 0) : 1'b1;
            wready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (s_rd) buf_rd_data = mem[s_rd_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int src, input int cnt, input int mode);
        logic [511:0] row;
        logic [9:0] a;
        for (int r = 0; r < cnt; r++) begin
            a = 10'(src + r);
            for (int e = 0; e < 16; e++) row[32*e +: 32] = exp_elem(mode, r, a, e);
            mem[a] = row;
        end
    endtask

    task automatic push_exp(input int src, input int cnt, input logic [31:0] base, input int mode);
        logic [9:0] a;
        for (int r = 0; r < cnt; r++) begin
            a = 10'(src + r);
            exp_rd.push_back(a);
            exp_aw.push_back(base + 32'(r) * 32'd64);
            for (int j = 0; j < 8; j++)
                exp_w.push_back({exp_elem(mode, r, a, 2*j+1), exp_elem(mode, r, a, 2*j)});
        end
    endtask

    task automatic check_zero(input string name);
        chk({name, "_ctl"}, {busy, done, error, buf_rd_en, awvalid, wvalid, wlast, bready}, 8'h00);
        chk({name, "_awaddr"}, awaddr, 32'h0);
        chk({name, "_wdata"}, wdata, 64'h0);
        chk({name, "_rdaddr"}, buf_rd_addr, 10'h0);
    endtask

    task automatic run_dump(input int src, input int cnt, input logic [31:0] base, input int mode,
                            input bit exp_err, input int exp_lat, input bit dbl);
        int d0, a0, n_aw, waitc;
        bit fired;
        n_aw = (cnt != 0 && base[5:0] == 6'd0) ? cnt : 0;
        push_exp(src, n_aw, base, mode);
        d0 = done_cnt;
        a0 = aw_count;
        b_base = b_count;
        src_row = 10'(src); row_count = 16'(cnt); ddr_base = base;
        start = 1'b1;
        tick();
        start = 1'b0;
        fired = 0;
        waitc = 0;
        while (done_cnt == d0 && waitc < 6000) begin
            if (dbl && !fired && aw_count - a0 >= 2) begin
                src_row = 10'd5; row_count = 16'd3; ddr_base = 32'h0000_1000;
                start = 1'b1;
                tick();
                start = 1'b0;
                fired = 1;
            end else begin
                tick();
            end
            waitc++;
        end
        chk("done_timeout", waitc < 6000, 1'b1);
        repeat (4) tick();
        chk("done_once", done_cnt - d0, 1);
        chk("aw_total", aw_count - a0, n_aw);
        chk("sb_drain", {exp_aw.size(), exp_w.size(), exp_rd.size()}, 0);
        chk("error_flag", error, exp_err);
        if (exp_lat > 0) chk("done_latency", last_lat, exp_lat);
        if (dbl) chk("second_start_issued", fired, 1'b1);
    endtask

    initial begin
        int a0, waitc;
        repeat (3) tick();
        check_zero("reset");
        rst_n = 1'b1;
        repeat (2) tick();

        // Nominal dump, always-ready slave
        fill(48, 16, 0);
        run_dump(48, 16, 32'h8000_0000, 0, 1'b0, 192, 1'b0);
        chk("aw_latency", aw_lat, 3);
`ifdef TPU_RESULT_WRITER_PERF_EN
        chk("perf_beats", perf_beats, 128);
        chk("perf_stall", perf_stall_cycles, 0);
`endif

        // Element ordering: stream word k equals k
        fill(100, 16, 1);
        run_dump(100, 16, 32'h1000_0000, 1, 1'b0, 192, 1'b0);

        // Random backpressure on AW, W and B
        bp = 1;
        run_dump(100, 16, 32'h2000_0040, 1, 1'b0, 0, 1'b0);
        bp = 0;

        // SLVERR on the third burst; dump still completes
        err_burst = 2;
        run_dump(48, 16, 32'h8000_0000, 0, 1'b1, 192, 1'b0);
        err_burst = -1;
        run_dump(48, 16, 32'h8000_0000, 0, 1'b0, 192, 1'b0);

        // Misaligned base and empty dump
        run_dump(48, 16, 32'h8000_0010, 0, 1'b1, 1, 1'b0);
        run_dump(48, 0, 32'h8000_0000, 0, 1'b0, 1, 1'b0);

        // Row address wrap 1020..1023, 0..3
        fill(1020, 8, 2);
        run_dump(1020, 8, 32'h4000_0000, 2, 1'b0, 96, 1'b0);

        // Start during the second burst is ignored
        run_dump(48, 16, 32'h8000_0000, 0, 1'b0, 192, 1'b1);

        // Asynchronous reset during beat 4 of row 5
        push_exp(48, 16, 32'h8000_0000, 0);
        a0 = aw_count;
        src_row = 10'd48; row_count = 16'd16; ddr_base = 32'h8000_0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        waitc = 0;
        while (!(aw_count - a0 == 6 && beat_in_row == 4) && waitc < 3000) begin
            tick();
            waitc++;
        end
        chk("rst_reach", waitc < 3000, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_zero("rst_mid");
        exp_aw.delete(); exp_w.delete(); exp_rd.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        run_dump(48, 16, 32'h8000_0000, 0, 1'b0, 192, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=%0t required=<500000", $time);
        $fatal(1, "simulation time limit reached");
    end

endmodule
